// File: rtl/fake_dsp_if.sv
// Sample/coefficient bus for fake_dsp: window shift inputs, MAC step inputs and result outputs.
interface fake_dsp_if #(
   parameter int unsigned NTAPS = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned SW    = 25,
   parameter int unsigned RW    = 34
);
   logic                      en;
   logic [SW-1:0]             signal;
   logic [NTAPS-1:0][DW-1:0]  signal_window;
   logic                      ce;
   logic [DW-1:0]             tap;
   logic [7:0]                tapnum;
   logic [RW-1:0]             result_o;
   logic                      done;

   modport master (
      output en, signal, ce, tap, tapnum,
      input  signal_window, result_o, done
   );

   modport slave (
      input  en, signal, ce, tap, tapnum,
      output signal_window, result_o, done
   );
endinterface

// File: rtl/fake_dsp.sv
// 4-tap FIR datapath: shifting sample window plus serial signed MAC.
// Option FAKE_DSP_DONE_HOLD_EN: done holds until the next first step instead of pulsing.
module fake_dsp #(
   parameter int unsigned NTAPS = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned RW    = 34
) (
   input logic      clk,
   input logic      reset_n,
   fake_dsp_if.slave bus
);
   localparam int unsigned IW = $clog2(NTAPS);

   logic [NTAPS-1:0][DW-1:0] r_window;
   logic [RW-1:0]            r_acc;
   logic [RW-1:0]            r_result;
   logic                     r_done;

   logic [IW-1:0]            w_idx;
   logic                     w_first;
   logic                     w_last;
   logic signed [2*DW-1:0]   w_prod;
   logic [RW-1:0]            w_prod_ext;
   logic [RW-1:0]            w_sum;

   assign w_idx      = bus.tapnum[IW-1:0];
   assign w_first    = (w_idx == '0);
   assign w_last     = (w_idx == IW'(NTAPS - 1));
   // Product uses the registered window, so a same-cycle shift is not seen by the MAC
   assign w_prod     = $signed(bus.tap) * $signed(r_window[w_idx]);
   assign w_prod_ext = {{(RW - 2*DW){w_prod[2*DW-1]}}, w_prod};
   assign w_sum      = w_first ? w_prod_ext : (r_acc + w_prod_ext);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_window <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         if (bus.en) begin
            for (int i = NTAPS - 1; i > 0; i--) begin
               r_window[i] <= r_window[i-1];
            end
            r_window[0] <= bus.signal[23:8];
         end
         if (bus.ce) begin
            r_acc <= w_sum;
            if (w_last) begin
               r_result <= w_sum;
            end
         end
`ifdef FAKE_DSP_DONE_HOLD_EN
         if (bus.ce && w_first) begin
            r_done <= 1'b0;
         end else if (bus.ce && w_last) begin
            r_done <= 1'b1;
         end
`else
         r_done <= bus.ce && w_last;
`endif
      end
   end

   assign bus.signal_window = r_window;
   assign bus.result_o      = r_result;
   assign bus.done          = r_done;
endmodule

// File: tb/tb_fake_dsp.sv
// Self-checking bench for fake_dsp: window model plus scoreboard of expected MAC results.
module tb_fake_dsp;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fake_dsp_if bus ();
   fake_dsp dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int n_checks = 0;
   int n_fails  = 0;

   logic [33:0]        exp_q[$];
   logic [15:0]        m_win[4];
   logic signed [33:0] m_acc;
   logic               done_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_win[i] = '0;
      m_acc = '0;
   endtask

   // Drive one cycle of stimulus, update the model, return at posedge+1.
   task automatic cycle(input bit e, input logic [23:0] s, input bit c,
                        input logic [15:0] t, input logic [7:0] n);
      logic signed [31:0] prod;
      logic signed [33:0] sum;
      bus.en = e; bus.signal = {1'b1, s}; bus.ce = c; bus.tap = t; bus.tapnum = n;
      if (c) begin
         prod = $signed(t) * $signed(m_win[n[1:0]]);
         sum  = (n[1:0] == 2'd0) ? 34'(prod) : m_acc + 34'(prod);
         m_acc = sum;
         if (n[1:0] == 2'd3) exp_q.push_back(sum);
      end
      if (e) begin
         m_win[3] = m_win[2]; m_win[2] = m_win[1]; m_win[1] = m_win[0]; m_win[0] = s[23:8];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 24'h0, 1'b0, 16'h0, 8'h0);
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      // a ends up in w[0], d in w[3]
      cycle(1'b1, {d, 8'h5A}, 1'b0, 16'h0, 8'h0);
      cycle(1'b1, {c, 8'h5A}, 1'b0, 16'h0, 8'h0);
      cycle(1'b1, {b, 8'h5A}, 1'b0, 16'h0, 8'h0);
      cycle(1'b1, {a, 8'h5A}, 1'b0, 16'h0, 8'h0);
   endtask

   task automatic check_window(input string tag);
      for (int i = 0; i < 4; i++) check(tag, 64'(bus.signal_window[i]), 64'(m_win[i]));
   endtask

   task automatic mac4(input logic [15:0] t);
      for (int i = 0; i < 4; i++) cycle(1'b0, 24'h0, 1'b1, t, 8'(i));
   endtask

   // Scoreboard: compare on each rising edge of done.
   always @(negedge clk) begin
      if (reset_n && bus.done && !done_prev) begin
         if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
         else check("sb_result", 64'(bus.result_o), 64'(exp_q.pop_front()));
      end
      done_prev <= bus.done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      bus.en = 1'b0; bus.signal = '0; bus.ce = 1'b0; bus.tap = '0; bus.tapnum = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_window("reset_window");
      check("reset_result", 64'(bus.result_o), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      reset_n = 1'b1;
      idle();

      // Shift and hold
      cycle(1'b1, 24'h111111, 1'b0, 16'h0, 8'h0);
      cycle(1'b0, 24'h000000, 1'b0, 16'h0, 8'h0);
      cycle(1'b1, 24'h222222, 1'b0, 16'h0, 8'h0);
      cycle(1'b1, 24'h333333, 1'b0, 16'h0, 8'h0);
      cycle(1'b1, 24'h444444, 1'b0, 16'h0, 8'h0);
      check("shift_w0", 64'(bus.signal_window[0]), 64'h4444);
      check("shift_w1", 64'(bus.signal_window[1]), 64'h3333);
      check("shift_w2", 64'(bus.signal_window[2]), 64'h2222);
      check("shift_w3", 64'(bus.signal_window[3]), 64'h1111);
      cycle(1'b1, 24'h555555, 1'b0, 16'h0, 8'h0);
      check("shift2_w0", 64'(bus.signal_window[0]), 64'h5555);
      check("shift2_w3", 64'(bus.signal_window[3]), 64'h2222);
      check_window("shift2_window");

      // Basic MAC and done pulse width
      load(16'd1, 16'd2, 16'd3, 16'd4);
      mac4(16'h1234);
      check("mac_result", 64'(bus.result_o), 64'h0B608);
      check("mac_done", 64'(bus.done), 64'd1);
      idle();
`ifdef FAKE_DSP_DONE_HOLD_EN
      check("done_held", 64'(bus.done), 64'd1);
      idle();
      check("done_held2", 64'(bus.done), 64'd1);
`else
      check("done_pulse", 64'(bus.done), 64'd0);
`endif
      check("result_hold", 64'(bus.result_o), 64'h0B608);

      // Signed full scale, then mixed signs
      load(16'h8000, 16'h8000, 16'h8000, 16'h8000);
      cycle(1'b0, 24'h0, 1'b1, 16'h8000, 8'h00);
      check("done_clear_on_first", 64'(bus.done), 64'd0);
      for (int i = 1; i < 4; i++) cycle(1'b0, 24'h0, 1'b1, 16'h8000, 8'(i));
      check("fullscale", 64'(bus.result_o), 64'h1_0000_0000);
      load(16'd1, 16'd2, 16'd3, 16'd4);
      mac4(16'hFFFF);
      check("mixed_sign", 64'(bus.result_o), 64'h3_FFFF_FFF6);

      // Stall between steps 1 and 2
      cycle(1'b0, 24'h0, 1'b1, 16'd1, 8'd0);
      cycle(1'b0, 24'h0, 1'b1, 16'd2, 8'd1);
      idle();
      idle();
      cycle(1'b0, 24'h0, 1'b1, 16'd3, 8'd2);
      cycle(1'b0, 24'h0, 1'b1, 16'd4, 8'd3);
      check("stall_result", 64'(bus.result_o), 64'd30);

      // Restart mid-sum, upper tapnum bits ignored, shift on the last step
      cycle(1'b0, 24'h0, 1'b1, 16'd100, 8'h40);
      cycle(1'b0, 24'h0, 1'b1, 16'd100, 8'h41);
      cycle(1'b0, 24'h0, 1'b1, 16'd1, 8'h40);
      cycle(1'b0, 24'h0, 1'b1, 16'd2, 8'h41);
      cycle(1'b0, 24'h0, 1'b1, 16'd3, 8'h42);
      cycle(1'b1, 24'h7FFF00, 1'b1, 16'd4, 8'h43);
      check("restart_result", 64'(bus.result_o), 64'd30);
      check_window("same_cycle_shift");

      // Async reset mid-sum, no clock edge needed
      cycle(1'b1, 24'h123400, 1'b1, 16'd7, 8'd0);
      cycle(1'b0, 24'h0, 1'b1, 16'd7, 8'd1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_w0", 64'(bus.signal_window[0]), 64'd0);
      check_window("async_window");
      check("async_result", 64'(bus.result_o), 64'd0);
      check("async_done", 64'(bus.done), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      load(16'd5, 16'd6, 16'd7, 16'd8);
      mac4(16'd2);
      check("post_reset_result", 64'(bus.result_o), 64'd52);
      idle();
      idle();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
